command_controller: RTL and testbench

- Byte-stream command decoder between a byte receiver (e.g. UART RX) and a register file.
- Frames each 6-byte command and issues a register write or read strobe:
  - 1 command byte
  - 1 address byte
  - 4 value bytes, MSB first
- Write commands drive address, data and a stretched write-enable pulse. Read commands drive a read address and a one-cycle read strobe.

---
 rtl/command_controller_pkg.sv | 16 +
 rtl/command_controller_pulse_stretcher.sv | 33 +++
 rtl/command_controller.sv | 149 ++++++++++++++
 tb/tb_command_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/command_controller_pkg.sv
// command_controller_pkg
//   Shared constants and the framing FSM state type for command_controller.
//   Command codes, the number of value bytes per frame, and state_t.
package command_controller_pkg;

  localparam logic [7:0] READ_CMD    = 8'h00;
  localparam logic [7:0] WRITE_CMD   = 8'hAA;
  localparam int         VALUE_BYTES = 4;

  typedef enum logic [1:0] {
    S_CMD,
    S_ADDR,
    S_VAL
  } state_t;

endpackage

// File: rtl/command_controller_pulse_stretcher.sv
// pulse_stretcher
//   Turns a single-cycle trigger into a pulse of LEN cycles. The pulse starts
//   on the cycle after the trigger. A retrigger while the pulse is active
//   reloads the down-counter, so the pulse stays high without a gap.
// Ports:
//   clk      in   system clock
//   i_reset  in   synchronous active-high reset, kills any active pulse
//   i_trig   in   load the counter with LEN
//   o_pulse  out  high while the counter is non-zero
module pulse_stretcher #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_trig,
  output logic o_pulse
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_cnt <= 8'd0;
    end else if (i_trig) begin
      r_cnt <= 8'(LEN);
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_pulse = (r_cnt != 8'd0);

endmodule

// File: rtl/command_controller.sv
// command_controller
//   Frames a byte stream into 6-byte commands (cmd, addr, 4 value bytes MSB
//   first) and issues register reads or writes.
//   Optional macro COMMAND_CONTROLLER_FRAME_TIMEOUT_EN: abandon a partial frame
//   after TIMEOUT_CYCLES consecutive idle cycles.
// Ports:
//   clk       in   system clock
//   i_reset   in   synchronous active-high reset
//   i_data    in   received byte, qualified by i_dv
//   i_dv      in   byte-valid strobe
//   o_w_addr  out  write address, held until the next write
//   o_w_data  out  write data, held until the next write
//   o_w_en    out  stretched write enable (PULSE_W_EN_MAX_LEN cycles)
//   o_r_addr  out  read address, held until the next read
//   o_r_en    out  single-cycle read strobe
//
// state  | meaning
// S_CMD  | waiting for the command byte
// S_ADDR | waiting for the address byte
// S_VAL  | collecting the four value bytes
module command_controller
  import command_controller_pkg::*;
#(
  parameter int PULSE_W_EN_MAX_LEN = 4,
  parameter int TIMEOUT_CYCLES     = 1000000
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic [7:0]  i_data,
  input  logic        i_dv,
  output logic [7:0]  o_w_addr,
  output logic [31:0] o_w_data,
  output logic        o_w_en,
  output logic [7:0]  o_r_addr,
  output logic        o_r_en
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cmd;
  logic [7:0]  r_addr;
  logic [23:0] r_value;   // only the first three value bytes need storing
  logic [2:0]  r_cnt;
  logic [7:0]  r_w_addr;
  logic [31:0] r_w_data;
  logic [7:0]  r_r_addr;
  logic        r_r_en;
  logic        w_last_val;
  logic        w_write_done;
  logic        w_read_hit;
  logic        w_timeout;

  assign w_last_val   = (r_state == S_VAL) && i_dv && (r_cnt == 3'(VALUE_BYTES - 1));
  assign w_write_done = w_last_val && (r_cmd == WRITE_CMD);
  assign w_read_hit   = (r_state == S_ADDR) && i_dv && (r_cmd == READ_CMD);

`ifdef COMMAND_CONTROLLER_FRAME_TIMEOUT_EN
  logic [31:0] r_idle;

  always_ff @(posedge clk) begin
    if (i_reset || i_dv || (r_state == S_CMD)) begin
      r_idle <= 32'd0;
    end else begin
      r_idle <= r_idle + 32'd1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
  assign w_timeout = (r_state != S_CMD) && !i_dv &&
                     (r_idle == 32'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_CMD;
    end else if (i_dv) begin
      case (r_state)
        S_CMD:   w_state_nxt = S_ADDR;
        S_ADDR:  w_state_nxt = S_VAL;
        S_VAL:   w_state_nxt = w_last_val ? S_CMD : S_VAL;
        default: w_state_nxt = S_CMD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_cmd    <= 8'd0;
      r_addr   <= 8'd0;
      r_value  <= 24'd0;
      r_cnt    <= 3'd0;
      r_w_addr <= 8'd0;
      r_w_data <= 32'd0;
      r_r_addr <= 8'd0;
      r_r_en   <= 1'b0;
    end else begin
      r_r_en <= w_read_hit;
      if (i_dv) begin
        case (r_state)
          S_CMD:  r_cmd <= i_data;
          S_ADDR: begin
            r_addr <= i_data;
            r_cnt  <= 3'd0;
          end
          S_VAL: begin
            r_value <= {r_value[15:0], i_data};
            r_cnt   <= r_cnt + 3'd1;
          end
          default: ;
        endcase
      end
      if (w_read_hit) begin
        r_r_addr <= i_data;
      end
      if (w_write_done) begin
        r_w_addr <= r_addr;
        r_w_data <= {r_value, i_data};
      end
    end
  end

  pulse_stretcher #(
    .LEN (PULSE_W_EN_MAX_LEN)
  ) u_w_en_stretch (
    .clk     (clk),
    .i_reset (i_reset),
    .i_trig  (w_write_done),
    .o_pulse (o_w_en)
  );

  assign o_w_addr = r_w_addr;
  assign o_w_data = r_w_data;
  assign o_r_addr = r_r_addr;
  assign o_r_en   = r_r_en;

endmodule

// File: tb/tb_command_controller.sv
// tb_command_controller
//   Two instances (write pulse length 1 and 4) share one byte stream. A
//   frame-level model predicts every output; directed frames pin literal
//   values, then randomized traffic runs against the model.
module tb_command_controller;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic        i_dv = 1'b0;

  logic [7:0]  w_addr1, r_addr1, w_addr4, r_addr4;
  logic [31:0] w_data1, w_data4;
  logic        w_en1, r_en1, w_en4, r_en4;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  command_controller #(.PULSE_W_EN_MAX_LEN(1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
    .o_w_addr(w_addr1), .o_w_data(w_data1), .o_w_en(w_en1),
    .o_r_addr(r_addr1), .o_r_en(r_en1));

  command_controller #(.PULSE_W_EN_MAX_LEN(4), .TIMEOUT_CYCLES(TMO)) dut4 (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
    .o_w_addr(w_addr4), .o_w_data(w_data4), .o_w_en(w_en4),
    .o_r_addr(r_addr4), .o_r_en(r_en4));

  // Frame-level model: collect bytes, act on byte 2 (read) and byte 6 (write).
  logic [7:0]  m_frame [6];
  int          m_n = 0;
  int          m_idle = 0;
  logic [7:0]  m_r_addr = 8'h00, m_w_addr = 8'h00;
  logic [31:0] m_w_data = 32'h0;
  logic        m_r_en = 1'b0;
  int          m_rem1 = 0, m_rem4 = 0;

  always @(posedge clk) begin
    if (i_reset) begin
      m_n = 0; m_idle = 0;
      m_r_addr = 8'h00; m_r_en = 1'b0;
      m_w_addr = 8'h00; m_w_data = 32'h0;
      m_rem1 = 0; m_rem4 = 0;
    end else begin
      m_r_en = 1'b0;
      if (m_rem1 > 0) m_rem1--;
      if (m_rem4 > 0) m_rem4--;
`ifdef COMMAND_CONTROLLER_FRAME_TIMEOUT_EN
      if (i_dv || m_n == 0) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_n = 0;
          m_idle = 0;
        end
      end
`endif
      if (i_dv) begin
        m_frame[m_n] = i_data;
        m_n++;
        if (m_n == 2 && m_frame[0] == 8'h00) begin
          m_r_addr = i_data;
          m_r_en = 1'b1;
        end
        if (m_n == 6) begin
          if (m_frame[0] == 8'hAA) begin
            m_w_addr = m_frame[1];
            m_w_data = {m_frame[2], m_frame[3], m_frame[4], m_frame[5]};
            m_rem1 = 1;
            m_rem4 = 4;
          end
          m_n = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("m1_w_addr", {24'h0, w_addr1}, {24'h0, m_w_addr});
      chk("m1_w_data", w_data1, m_w_data);
      chk("m1_w_en",   {31'h0, w_en1}, {31'h0, (m_rem1 > 0)});
      chk("m1_r_addr", {24'h0, r_addr1}, {24'h0, m_r_addr});
      chk("m1_r_en",   {31'h0, r_en1}, {31'h0, m_r_en});
      chk("m4_w_addr", {24'h0, w_addr4}, {24'h0, m_w_addr});
      chk("m4_w_data", w_data4, m_w_data);
      chk("m4_w_en",   {31'h0, w_en4}, {31'h0, (m_rem4 > 0)});
      chk("m4_r_addr", {24'h0, r_addr4}, {24'h0, m_r_addr});
      chk("m4_r_en",   {31'h0, r_en4}, {31'h0, m_r_en});
    end
  end

  // Called at a negedge; returns at the next negedge with the byte consumed.
  task automatic drive_byte(input logic [7:0] b);
    i_dv = 1'b1;
    i_data = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_dv = 1'b0;
    i_data = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    i_dv = 1'b0;
    i_reset = 1'b1;
    repeat (n) @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input int gap);
    for (int k = 0; k < 6; k++) begin
      drive_byte(f[47 - 8*k -: 8]);
      if (k < 5 && gap > 0) idle(gap);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos;
    int r;
    logic [7:0] b;

    @(negedge clk);
    do_reset(2);
    checking = 1'b1;
    chk("rst_w_addr", {24'h0, w_addr4}, 32'h0);
    chk("rst_w_data", w_data4, 32'h0);
    chk("rst_w_en",   {31'h0, w_en4}, 32'h0);
    chk("rst_r_addr", {24'h0, r_addr4}, 32'h0);
    chk("rst_r_en",   {31'h0, r_en4}, 32'h0);

    // READ frame, bytes 10 cycles apart
    drive_byte(8'h00); idle(9);
    drive_byte(8'h12);
    chk("rd_r_en_hi", {31'h0, r_en4}, 32'h1);
    chk("rd_r_addr",  {24'h0, r_addr4}, 32'h12);
    idle(1);
    chk("rd_r_en_lo", {31'h0, r_en4}, 32'h0);
    idle(8);
    drive_byte(8'h12); idle(9);
    drive_byte(8'h34); idle(9);
    drive_byte(8'h56); idle(9);
    drive_byte(8'h78); idle(1);
    chk("rd_no_w_en",  {31'h0, w_en4}, 32'h0);
    chk("rd_w_addr_0", {24'h0, w_addr4}, 32'h0);
    chk("rd_w_data_0", w_data4, 32'h0);

    // WRITE, gapped; check both pulse widths
    send_frame(48'hAA_21_87_65_43_21, 3);
    chk("wr1_w_addr", {24'h0, w_addr1}, 32'h21);
    chk("wr1_w_data", w_data1, 32'h87654321);
    chk("wr1_w_en",   {31'h0, w_en1}, 32'h1);
    chk("wr4_w_en_1", {31'h0, w_en4}, 32'h1);
    idle(1);
    chk("wr1_w_en_lo", {31'h0, w_en1}, 32'h0);
    chk("wr1_hold",    w_data1, 32'h87654321);
    idle(2);
    chk("wr4_w_en_4", {31'h0, w_en4}, 32'h1);
    idle(1);
    chk("wr4_w_en_lo", {31'h0, w_en4}, 32'h0);

    // two writes back to back
    send_frame(48'hAA_21_87_65_43_21, 0);
    send_frame(48'hAA_05_00_00_00_FF, 0);
    chk("b2b_w_addr", {24'h0, w_addr4}, 32'h05);
    chk("b2b_w_data", w_data4, 32'h000000FF);
    chk("b2b_w_en",   {31'h0, w_en4}, 32'h1);
    idle(3);
    chk("b2b_w_en_4", {31'h0, w_en4}, 32'h1);
    idle(1);
    chk("b2b_w_en_lo", {31'h0, w_en4}, 32'h0);

    // unknown command, then a write proving framing survives
    send_frame(48'h55_10_01_02_03_04, 0);
    idle(1);
    chk("unk_w_addr", {24'h0, w_addr4}, 32'h05);
    chk("unk_r_en",   {31'h0, r_en4}, 32'h0);
    chk("unk_w_en",   {31'h0, w_en4}, 32'h0);
    send_frame(48'hAA_33_DE_AD_BE_EF, 0);
    chk("unk_wr_addr", {24'h0, w_addr4}, 32'h33);
    chk("unk_wr_data", w_data4, 32'hDEADBEEF);
    idle(5);

    // reset mid-frame
    drive_byte(8'hAA); drive_byte(8'h44); drive_byte(8'h11);
    do_reset(1);
    chk("mid_rst_w_en", {31'h0, w_en4}, 32'h0);
    chk("mid_rst_addr", {24'h0, w_addr4}, 32'h0);
    drive_byte(8'h00); drive_byte(8'h77);
    chk("post_rst_r_en",   {31'h0, r_en4}, 32'h1);
    chk("post_rst_r_addr", {24'h0, r_addr4}, 32'h77);
    drive_byte(8'hAA); drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
    idle(1);
    chk("post_rst_w_en", {31'h0, w_en4}, 32'h0);
    idle(4);

`ifdef COMMAND_CONTROLLER_FRAME_TIMEOUT_EN
    drive_byte(8'hAA); drive_byte(8'h44);
    idle(60);
    send_frame(48'hAA_66_00_00_00_01, 0);
    chk("to_w_addr", {24'h0, w_addr4}, 32'h66);
    chk("to_w_data", w_data4, 32'h00000001);
    chk("to_w_en",   {31'h0, w_en4}, 32'h1);
    idle(5);
`endif

    // randomized traffic
    pos = 0;
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset(1);
        pos = 0;
      end else if (r < 55) begin
        if (pos == 0) begin
          case ($urandom_range(0, 3))
            0:       b = 8'h00;
            1, 2:    b = 8'hAA;
            default: b = 8'($urandom);
          endcase
        end else begin
          b = 8'($urandom);
        end
        drive_byte(b);
        pos = (pos + 1) % 6;
      end else if (r < 57) begin
        idle(60);
`ifdef COMMAND_CONTROLLER_FRAME_TIMEOUT_EN
        pos = 0;
`endif
      end else begin
        idle(1);
      end
    end
    idle(8);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
